hacnt: RTL

HACNT -- requirements
Module: hacnt

---
 rtl/hacnt_pkg.sv | 5 +
 rtl/hacnt_inc.sv | 27 ++
 rtl/hacnt.sv | 59 +++++
 3 files changed

// File: rtl/hacnt_pkg.sv
// Shared constants for the half-adder counter slice.
package hacnt_pkg;
  localparam int HACNT_WIDTH_DEFAULT = 8;
  localparam int HACNT_WIDTH_MAX     = 32;
endpackage

// File: rtl/hacnt_inc.sv
// Combinational ripple incrementer built from WIDTH half-adder stages.
module hacnt_inc
  import hacnt_pkg::*;
#(
  parameter int WIDTH = HACNT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] c;

  assign c[0] = en;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      assign sum[gi]  = q[gi] ^ c[gi];
      assign c[gi+1]  = q[gi] & c[gi];
    end
  endgenerate

  assign co = c[WIDTH];

endmodule

// File: rtl/hacnt.sv
// Loadable up-counter with terminal-count carry, optional saturation and sticky overflow.
module hacnt
  import hacnt_pkg::*;
#(
  parameter int WIDTH    = HACNT_WIDTH_DEFAULT,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic [WIDTH-1:0] sum_vec;
  logic             carry;

  hacnt_inc #(.WIDTH(WIDTH)) u_inc (
    .q   (q_reg),
    .en  (EN),
    .sum (sum_vec),
    .co  (carry)
  );

  always_comb begin
    q_next   = q_reg;
    ovf_next = ovf_reg;
    if (LD) begin
      q_next   = D;
      ovf_next = 1'b0;
    end else if (EN) begin
      // On wrap the sum is already zero; saturation simply keeps all-ones.
      q_next   = (carry && (SATURATE != 0)) ? q_reg : sum_vec;
      ovf_next = ovf_reg | carry;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      ovf_reg <= ovf_next;
    end
  end

  assign Q   = q_reg;
  assign OVF = ovf_reg;
  assign CO  = carry;

endmodule
